// File: rtl/if_id_skid.sv
// Fetch -> decode pipeline boundary: registered payload behind valid/ready with a
// one-entry skid so in_ready_o is a flop output and never sees out_ready_i.
module if_id_skid #(
  parameter int unsigned          XLEN                = 64,
  parameter int unsigned          INST_LEN            = 32,
  parameter int unsigned          TRAP_LEN            = 32,
  parameter int unsigned          TRAP_MISALIGNED_BIT = 0,
  parameter logic [INST_LEN-1:0]  NOP_INST            = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     in_addr_i,
  input  logic [INST_LEN-1:0] in_inst_i,
  input  logic [TRAP_LEN-1:0] in_trap_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     out_addr_o,
  output logic [INST_LEN-1:0] out_inst_o,
  output logic [TRAP_LEN-1:0] out_trap_o
);

  // Handshake: a transfer happens on an edge where valid && ready are both high;
  // the offering side keeps its payload stable until that edge.

  localparam logic [TRAP_LEN-1:0] MISALIGNED_MASK = TRAP_LEN'(1) << TRAP_MISALIGNED_BIT;

  logic                main_valid;
  logic [XLEN-1:0]     main_addr;
  logic [INST_LEN-1:0] main_inst;
  logic [TRAP_LEN-1:0] main_trap;

  logic                skid_valid;
  logic [XLEN-1:0]     skid_addr;
  logic [INST_LEN-1:0] skid_inst;
  logic [TRAP_LEN-1:0] skid_trap;

  logic                ready_q;
  logic [TRAP_LEN-1:0] in_trap_cap;
  logic                accept;
  logic                advance;
  logic                to_skid;

  // Fetch does not check alignment, so the misaligned trap is raised here.
  always_comb begin
    in_trap_cap = in_trap_i;
    if (in_addr_i[1:0] != 2'b00) begin
      in_trap_cap = in_trap_i | MISALIGNED_MASK;
    end
  end

  assign accept  = in_valid_i && ready_q && !flush_i;
  assign advance = !main_valid || out_ready_i;
  assign to_skid = accept && !advance;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      main_valid <= 1'b0;
      main_addr  <= '0;
      main_inst  <= NOP_INST;
      main_trap  <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (advance) begin
      if (skid_valid) begin
        // ready_q was low, so nothing is accepted on a release edge.
        main_valid <= 1'b1;
        main_addr  <= skid_addr;
        main_inst  <= skid_inst;
        main_trap  <= skid_trap;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_addr  <= in_addr_i;
        main_inst  <= in_inst_i;
        main_trap  <= in_trap_cap;
      end else begin
        main_valid <= 1'b0;
        main_addr  <= '0;
        main_inst  <= NOP_INST;
        main_trap  <= '0;
      end
    end else if (to_skid) begin
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end

  // Skid payload is only meaningful while skid_valid is set.
  always_ff @(posedge clk) begin
    if (to_skid && !rst) begin
      skid_addr <= in_addr_i;
      skid_inst <= in_inst_i;
      skid_trap <= in_trap_cap;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid;
  assign out_addr_o  = main_addr;
  assign out_inst_o  = main_inst;
  assign out_trap_o  = main_trap;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table, then randomized traffic checked
// against a queue model of held entries.
module tb_if_id_skid;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned INST_LEN = 32;
  localparam int unsigned TRAP_LEN = 32;
  localparam int unsigned EW       = XLEN + INST_LEN + TRAP_LEN;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [XLEN-1:0]     in_addr_i;
  logic [INST_LEN-1:0] in_inst_i;
  logic [TRAP_LEN-1:0] in_trap_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [XLEN-1:0]     out_addr_o;
  logic [INST_LEN-1:0] out_inst_o;
  logic [TRAP_LEN-1:0] out_trap_o;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  if_id_skid dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_addr_i   (in_addr_i),
    .in_inst_i   (in_inst_i),
    .in_trap_i   (in_trap_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_addr_o  (out_addr_o),
    .out_inst_o  (out_inst_o),
    .out_trap_o  (out_trap_o)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] addr;
    logic [31:0] trap;
    logic        exp_valid;
    logic        exp_ready;
    logic [63:0] exp_addr;
    logic [31:0] exp_trap;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk_inst(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic add(input logic r, f, iv, ordy, input logic [63:0] a, input logic [31:0] t,
                     input logic ev, er, input logic [63:0] ea, input logic [31:0] et);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy;
    v.addr = a; v.trap = t;
    v.exp_valid = ev; v.exp_ready = er; v.exp_addr = ea; v.exp_trap = et;
    tbl.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, f, iv, ordy, input logic [63:0] a,
                       input logic [31:0] inst, input logic [31:0] t);
    rst = r; flush_i = f; in_valid_i = iv; out_ready_i = ordy;
    in_addr_i = a; in_inst_i = inst; in_trap_i = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cap_trap(input logic [63:0] a, input logic [31:0] t);
    return (a[1:0] != 2'b00) ? (t | 32'h1) : t;
  endfunction

  // One edge of the model: the stage holds an ordered queue of at most two entries.
  task automatic model_edge(input logic r, f, iv, ordy, input logic [EW-1:0] e);
    int n;
    n = exp_q.size();
    if (r || f) begin
      exp_q.delete();
    end else begin
      if (n > 0 && ordy) void'(exp_q.pop_front());
      if (iv && n < 2) exp_q.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    logic [EW-1:0] f;
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      chk({tag, ".valid"}, 64'(out_valid_o), 64'd1);
      chk({tag, ".addr"},  out_addr_o, f[EW-1 -: XLEN]);
      chk({tag, ".inst"},  64'(out_inst_o), 64'(f[TRAP_LEN +: INST_LEN]));
      chk({tag, ".trap"},  64'(out_trap_o), 64'(f[TRAP_LEN-1:0]));
    end else begin
      chk({tag, ".valid"}, 64'(out_valid_o), 64'd0);
      chk({tag, ".addr"},  out_addr_o, 64'd0);
      chk({tag, ".inst"},  64'(out_inst_o), 64'(NOP));
      chk({tag, ".trap"},  64'(out_trap_o), 64'd0);
    end
    chk({tag, ".ready"}, 64'(in_ready_o), 64'(exp_q.size() < 2));
  endtask

  // Drive one cycle of stimulus, clock it, advance the model and compare.
  task automatic model_cycle(input string tag, input logic r, f, iv, ordy,
                             input logic [63:0] a, input logic [31:0] inst, input logic [31:0] t);
    drive(r, f, iv, ordy, a, inst, t);
    tick();
    model_edge(r, f, iv, ordy, {a, inst, cap_trap(a, t)});
    check_model(tag);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [63:0] a;
    logic [31:0] t;
    logic        iv, ordy, f;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 32'd0);

    //  rst flush iv rdy addr                t          ev er exp_addr            exp_trap
    add(1, 0, 0, 0, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(1, 0, 0, 0, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 1, 1, 64'h8000_0000,   32'h0,   1, 1, 64'h8000_0000,   32'h0);
    add(0, 0, 1, 1, 64'h8000_0004,   32'h0,   1, 1, 64'h8000_0004,   32'h0);
    add(0, 0, 1, 0, 64'h8000_0008,   32'h0,   1, 0, 64'h8000_0004,   32'h0);
    add(0, 0, 1, 0, 64'h8000_000C,   32'h0,   1, 0, 64'h8000_0004,   32'h0);
    add(0, 0, 1, 0, 64'h8000_000C,   32'h0,   1, 0, 64'h8000_0004,   32'h0);
    add(0, 0, 1, 1, 64'h8000_000C,   32'h0,   1, 1, 64'h8000_0008,   32'h0);
    add(0, 0, 1, 1, 64'h8000_000C,   32'h0,   1, 1, 64'h8000_000C,   32'h0);
    add(0, 0, 0, 1, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 1, 0, 64'h8000_0010,   32'h0,   1, 1, 64'h8000_0010,   32'h0);
    add(0, 0, 1, 0, 64'h8000_0014,   32'h0,   1, 0, 64'h8000_0010,   32'h0);
    add(0, 1, 1, 0, 64'h8000_0018,   32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 1, 1, 64'h8000_0100,   32'h0,   1, 1, 64'h8000_0100,   32'h0);
    add(0, 0, 0, 1, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 1, 0, 64'h8000_0020,   32'h0,   1, 1, 64'h8000_0020,   32'h0);
    add(0, 1, 1, 1, 64'h8000_0024,   32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 0, 1, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 1, 1, 64'h8000_0002,   32'h0,   1, 1, 64'h8000_0002,   32'h1);
    add(0, 0, 1, 1, 64'h8000_0004,   32'h4,   1, 1, 64'h8000_0004,   32'h4);
    add(0, 0, 1, 1, 64'h8000_0001,   32'h8000_0000, 1, 1, 64'h8000_0001, 32'h8000_0001);
    add(0, 0, 1, 1, 64'h8000_0003,   32'h1,   1, 1, 64'h8000_0003,   32'h1);
    add(0, 0, 0, 1, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 1, 0, 64'h8000_0030,   32'h0,   1, 1, 64'h8000_0030,   32'h0);
    add(0, 0, 1, 0, 64'h8000_0034,   32'h0,   1, 0, 64'h8000_0030,   32'h0);
    add(1, 1, 1, 1, 64'h8000_0038,   32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 0, 1, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 1, 0, 1, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);
    add(0, 0, 1, 1, 64'h8000_0040,   32'h0,   1, 1, 64'h8000_0040,   32'h0);
    add(0, 0, 0, 1, 64'h0,           32'h0,   0, 1, 64'h0,           32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].in_valid, tbl[i].out_ready,
            tbl[i].addr, mk_inst(tbl[i].addr), tbl[i].trap);
      tick();
      chk($sformatf("vec%0d.valid", i), 64'(out_valid_o), 64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d.ready", i), 64'(in_ready_o), 64'(tbl[i].exp_ready));
      chk($sformatf("vec%0d.addr", i), out_addr_o, tbl[i].exp_addr);
      chk($sformatf("vec%0d.inst", i), 64'(out_inst_o),
          tbl[i].exp_valid ? 64'(mk_inst(tbl[i].exp_addr)) : 64'(NOP));
      chk($sformatf("vec%0d.trap", i), 64'(out_trap_o), 64'(tbl[i].exp_trap));
    end

    // Randomized traffic against the queue model.
    model_cycle("rnd_rst", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 32'd0);
    for (int c = 0; c < 10000; c++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      t    = $urandom & 32'h0000_0F0E;
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      f    = ($urandom_range(0, 99) < 2);
      model_cycle("rnd", 1'b0, f, iv, ordy, a, $urandom, t);
    end

    // Long stall with fetch still offering: front entry held, nothing lost.
    for (int c = 0; c < 6; c++)
      model_cycle("stall", 1'b0, 1'b0, 1'b1, 1'b0, 64'h9000_0000 + 64'(4 * c), 32'hABC0_0000 + c, 32'h0);
    for (int c = 0; c < 4; c++)
      model_cycle("drain", 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 32'd0, 32'd0);

    // Reset with both entries full and flush raised.
    model_cycle("rf_fill", 1'b0, 1'b0, 1'b1, 1'b0, 64'hA000_0000, 32'h1111_1111, 32'h0);
    model_cycle("rf_fill", 1'b0, 1'b0, 1'b1, 1'b0, 64'hA000_0004, 32'h2222_2222, 32'h0);
    model_cycle("rf_rst",  1'b1, 1'b1, 1'b1, 1'b1, 64'hA000_0008, 32'h3333_3333, 32'h0);
    chk("rf_rst.inst_nop", 64'(out_inst_o), 64'(NOP));
    chk("rf_rst.ready",    64'(in_ready_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
